// File: rtl/layer1_gen_activation.sv
// layer1_gen_activation
// Activation stage behind the generator layer-1 MAC. It snapshots the Q8.8
// pre-activation vector on start and then activates LANES elements per clock
// into a flattened output bus for layer 2.
// Build option: define L1_ACT_LEAKY_EN for LeakyReLU with slope
// 2^-ALPHA_SHIFT. Without it, negative elements map to zero (plain ReLU).
module layer1_gen_activation #(
   parameter int N_ELEM      = 256,
   parameter int WIDTH       = 16,
   parameter int LANES       = 1,
   parameter int ALPHA_SHIFT = 3
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            start,
   input  logic signed [WIDTH*N_ELEM-1:0]  flat_input_flat,
   output logic signed [WIDTH*N_ELEM-1:0]  flat_output_flat,
   output logic                            busy,
   output logic                            done
);

   localparam int N_GROUPS = N_ELEM / LANES;
   localparam int GRP_W    = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1;
   localparam logic [GRP_W-1:0] LAST_GRP = GRP_W'(N_GROUPS - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t                          state;
   state_t                          state_next;
   logic [GRP_W-1:0]                grp;
   logic signed [WIDTH*N_ELEM-1:0]  snapshot;
   logic signed [WIDTH-1:0]         lane_result [LANES];
   logic                            accept;
   logic                            last_grp;

   // A lane count that does not divide the vector would leave a ragged tail
   // group, and a shift outside the word width is meaningless.
   if ((N_ELEM % LANES) != 0 || ALPHA_SHIFT < 0 || ALPHA_SHIFT >= WIDTH) begin : g_bad_params
      $error("layer1_gen_activation: invalid parameter combination");
   end

   // Negative inputs shift arithmetically (rounding toward -inf) and are never
   // saturated; the result always fits in WIDTH bits.
   function automatic logic signed [WIDTH-1:0] activate(input logic signed [WIDTH-1:0] x);
      logic signed [WIDTH-1:0] y;
      if (!x[WIDTH-1]) begin
         y = x;
      end else begin
`ifdef L1_ACT_LEAKY_EN
         y = x >>> ALPHA_SHIFT;
`else
         y = '0;
`endif
      end
      return y;
   endfunction

   assign accept   = (state == IDLE) && start;
   assign last_grp = (state == RUN) && (grp == LAST_GRP);

   // State register: reset returns to IDLE, which also aborts a run.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next state: start is only honoured in IDLE; RUN ends after the last group.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = RUN;
         RUN:     if (grp == LAST_GRP) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Outputs decoded from state: busy tracks RUN exactly.
   always_comb begin
      busy = (state == RUN);
   end

   // Activation of the current group's lanes, read from the frozen snapshot.
   always_comb begin
      for (int k = 0; k < LANES; k++) begin
         lane_result[k] = activate(snapshot[(int'(grp) * LANES + k) * WIDTH +: WIDTH]);
      end
   end

   // Snapshot capture and group counter; the counter holds on the last group
   // so it never wraps into a stale index.
   always_ff @(posedge clk) begin
      if (rst) begin
         snapshot <= '0;
         grp      <= '0;
      end else if (accept) begin
         snapshot <= flat_input_flat;
         grp      <= '0;
      end else if (state == RUN && !last_grp) begin
         grp <= grp + 1'b1;
      end
   end

   // Output vector: only the current group is written, so elements not yet
   // reached keep the previous run's values until overwritten.
   always_ff @(posedge clk) begin
      if (rst) begin
         flat_output_flat <= '0;
      end else if (state == RUN) begin
         for (int k = 0; k < LANES; k++) begin
            flat_output_flat[(int'(grp) * LANES + k) * WIDTH +: WIDTH] <= lane_result[k];
         end
      end
   end

   // Completion pulse: high for the single cycle after the last group lands;
   // it drops on the following edge whether or not a new start arrives.
   always_ff @(posedge clk) begin
      if (rst) begin
         done <= 1'b0;
      end else begin
         done <= last_grp;
      end
   end

endmodule

// File: tb/tb_layer1_gen_activation.sv
// tb_layer1_gen_activation
// Directed plus randomized bench for layer1_gen_activation with a
// behavioural integer model of the activation function.
// Honours L1_ACT_LEAKY_EN the same way as the design build.
module tb_layer1_gen_activation;

   localparam int N_ELEM      = 256;
   localparam int WIDTH       = 16;
   localparam int LANES       = 1;
   localparam int ALPHA_SHIFT = 3;
   localparam int N_GROUPS    = N_ELEM / LANES;

   logic                            clk = 1'b0;
   logic                            rst;
   logic                            start;
   logic signed [WIDTH*N_ELEM-1:0]  flat_in;
   logic signed [WIDTH*N_ELEM-1:0]  flat_out;
   logic                            busy;
   logic                            done;

   int checks   = 0;
   int failures = 0;

   logic [WIDTH-1:0] stim [N_ELEM];
   logic [WIDTH-1:0] snap [N_ELEM];
   int               exp_out [N_ELEM];

   always #5 clk = ~clk;

   layer1_gen_activation #(
      .N_ELEM(N_ELEM), .WIDTH(WIDTH), .LANES(LANES), .ALPHA_SHIFT(ALPHA_SHIFT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .flat_input_flat(flat_in),
      .flat_output_flat(flat_out),
      .busy(busy),
      .done(done)
   );

   // Reference activation in plain integer arithmetic: floor division by 2^shift.
   function automatic int refAct(input int x);
      int d;
      d = 2 ** ALPHA_SHIFT;
      if (x >= 0) return x;
`ifdef L1_ACT_LEAKY_EN
      return (x - (d - 1)) / d;
`else
      return 0 * d;
`endif
   endfunction

   function automatic int toInt(input logic [WIDTH-1:0] v);
      logic signed [WIDTH-1:0] s;
      s = v;
      return int'(s);
   endfunction

   function automatic logic signed [31:0] outElem(input int i);
      logic signed [WIDTH-1:0] v;
      v = flat_out[i*WIDTH +: WIDTH];
      return 32'(v);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                              input logic signed [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic checkVector(input string tag);
      for (int i = 0; i < N_ELEM; i++) begin
         checkOutput($sformatf("%s[%0d]", tag, i), outElem(i), exp_out[i]);
      end
   endtask

   // Drives stim onto the bus and pulses start; returns just after edge E0.
   task automatic applyStimulus();
      for (int i = 0; i < N_ELEM; i++) begin
         flat_in[i*WIDTH +: WIDTH] = stim[i];
         snap[i] = stim[i];
      end
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Waits (bounded) for done; 'already' is how many cycles after E0 have passed.
   task automatic waitDone(input string tag, input int already);
      int lat;
      int busyCnt;
      lat     = already;
      busyCnt = already;
      while (done !== 1'b1 && lat < 400) begin
         if (busy === 1'b1) busyCnt++;
         tick();
         lat++;
      end
      checkOutput({tag, "_latency"}, lat, N_GROUPS);
      checkOutput({tag, "_busy_cycles"}, busyCnt, N_GROUPS);
      checkOutput({tag, "_busy_at_done"}, 32'(busy), 0);
      for (int i = 0; i < N_ELEM; i++) exp_out[i] = refAct(toInt(snap[i]));
      checkVector(tag);
      tick();
      checkOutput({tag, "_done_one_cycle"}, 32'(done), 0);
      checkVector({tag, "_stable"});
   endtask

   initial begin
      rst     = 1'b1;
      start   = 1'b0;
      flat_in = '0;
      for (int i = 0; i < N_ELEM; i++) exp_out[i] = 0;

      // Reset state, and it holds with no start
      tick();
      tick();
      checkOutput("rst_busy", 32'(busy), 0);
      checkOutput("rst_done", 32'(done), 0);
      checkVector("rst_out");
      rst = 1'b0;
      repeat (5) tick();
      checkOutput("idle_busy", 32'(busy), 0);
      checkOutput("idle_done", 32'(done), 0);
      checkVector("idle_out");

      // All +1.0
      for (int i = 0; i < N_ELEM; i++) stim[i] = 16'h0100;
      applyStimulus();
      waitDone("pos", 0);

      // All -1.0
      for (int i = 0; i < N_ELEM; i++) stim[i] = 16'hFF00;
      applyStimulus();
      waitDone("neg", 0);
`ifdef L1_ACT_LEAKY_EN
      checkOutput("neg_e7", outElem(7), 32'shFFFF_FFE0);
`else
      checkOutput("neg_e7", outElem(7), 0);
`endif

      // Extremes
      for (int i = 0; i < N_ELEM; i++) stim[i] = 16'h0000;
      stim[0]   = 16'h7FFF;
      stim[1]   = 16'h8000;
      stim[255] = 16'hFFFF;
      applyStimulus();
      waitDone("corner", 0);
      checkOutput("corner_e0", outElem(0), 32'sh7FFF);
`ifdef L1_ACT_LEAKY_EN
      checkOutput("corner_e1", outElem(1), 32'shFFFF_F000);
      checkOutput("corner_e255", outElem(255), -1);
`else
      checkOutput("corner_e1", outElem(1), 0);
      checkOutput("corner_e255", outElem(255), 0);
`endif

      // Random vector; mid-run, unwritten elements still hold the last run
      for (int i = 0; i < N_ELEM; i++) stim[i] = WIDTH'($urandom);
      applyStimulus();
      repeat (100) tick();
      checkOutput("partial_written", outElem(99), refAct(toInt(snap[99])));
      checkOutput("partial_old", outElem(100), exp_out[100]);
      checkOutput("partial_old_last", outElem(255), exp_out[255]);
      waitDone("rand", 100);

      // Input change and second start during a run are ignored
      for (int i = 0; i < N_ELEM; i++) stim[i] = WIDTH'($urandom);
      applyStimulus();
      repeat (9) tick();
      for (int i = 0; i < N_ELEM; i++) flat_in[i*WIDTH +: WIDTH] = 16'h0200;
      start = 1'b1;
      tick();
      start = 1'b0;
      checkOutput("ignore_busy", 32'(busy), 1);
      waitDone("ignore", 10);

      // Reset mid-run aborts and clears everything
      for (int i = 0; i < N_ELEM; i++) stim[i] = WIDTH'($urandom);
      applyStimulus();
      repeat (99) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkOutput("abort_busy", 32'(busy), 0);
      checkOutput("abort_done", 32'(done), 0);
      for (int i = 0; i < N_ELEM; i++) exp_out[i] = 0;
      checkVector("abort_out");
      for (int i = 0; i < N_ELEM; i++) stim[i] = WIDTH'($urandom);
      applyStimulus();
      waitDone("after_abort", 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
